// File: rtl/uart_loader_pkg.sv
// Shared FSM state encoding and protocol byte values for the UART bootloader.
// The address helper keeps word-index to byte-address math in one place.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC1 = 3'd1,
    ST_LEN0  = 3'd2,
    ST_LEN1  = 3'd3,
    ST_DATA  = 3'd4,
    ST_CSUM  = 3'd5,
    ST_REPLY = 3'd6
  } loader_state_e;

  localparam logic [7:0] SYNC0 = 8'h55;
  localparam logic [7:0] SYNC1 = 8'hAA;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  // Byte address of payload word idx; wraps silently at 32 bits.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/uart_loader_if.sv
// UART byte stream, reply transmitter and RAM write port seen by the loader.
// master = loader side, slave = SoC side (uart_rx/uart_tx/RAM mux).
interface uart_loader_if;

  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;

  modport master (
    input  rx_valid, rx_data, tx_busy,
    output tx_start, tx_data, mem_addr, mem_wdata, mem_wmask
  );

  modport slave (
    output rx_valid, rx_data, tx_busy,
    input  tx_start, tx_data, mem_addr, mem_wdata, mem_wmask
  );

endinterface

// File: rtl/uart_loader_timeout.sv
// Inter-byte timeout: down-counter reloaded on clear or while disabled,
// expired pulses for one cycle on the CYCLES-th enabled cycle without a clear.
module loader_timeout #(
  parameter int unsigned CYCLES = 2_700_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] LOAD = W'(CYCLES);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear || !enable) begin
      cnt <= LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  // A byte in the same cycle as terminal count wins.
  assign expired = enable && !clear && (cnt == ONE);

endmodule

// File: rtl/uart_loader.sv
// UART bootloader: parses 55 AA N_lo N_hi payload CSUM frames, writes the
// payload words to RAM and holds the CPU in reset until a load succeeds.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for first sync byte 0x55
// SYNC1    | got 0x55, waiting for 0xAA (CPU not held yet)
// LEN0     | CPU held, waiting for N[7:0]
// LEN1     | waiting for N[15:8], then range check
// DATA     | collecting payload bytes, one RAM write per 4 bytes
// CSUM     | comparing received checksum against the running sum
// REPLY    | waiting for transmitter idle, then send ACK/NAK
module uart_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 8192,
  parameter int unsigned TIMEOUT_CYCLES = 2_700_000
) (
  input  logic           clk,
  input  logic           resetn,
  uart_loader_if.master  bus,
  output logic           cpu_resetn,
  output logic           loading,
  output logic           load_error
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_SYNC1 = ST_SYNC1;
  localparam logic [2:0] S_LEN0  = ST_LEN0;
  localparam logic [2:0] S_LEN1  = ST_LEN1;
  localparam logic [2:0] S_DATA  = ST_DATA;
  localparam logic [2:0] S_CSUM  = ST_CSUM;
  localparam logic [2:0] S_REPLY = ST_REPLY;

  logic [2:0]  state;
  logic [15:0] len;
  logic [15:0] idx;
  logic [7:0]  csum;
  logic [31:0] word;
  logic [1:0]  byte_cnt;
  logic [7:0]  reply;

  logic        timer_en;
  logic        tmo_expired;
  logic [31:0] word_next;
  logic [15:0] len_full;
  logic        len_bad;

  assign word_next = {bus.rx_data, word[31:8]};
  assign len_full  = {bus.rx_data, len[7:0]};
  assign len_bad   = (len_full == 16'd0) || (32'(len_full) > MAX_WORDS);

  assign timer_en = (state == S_SYNC1) || (state == S_LEN0) || (state == S_LEN1) ||
                    (state == S_DATA)  || (state == S_CSUM);

  loader_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (bus.rx_valid),
    .enable  (timer_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= S_IDLE;
      len            <= '0;
      idx            <= '0;
      csum           <= '0;
      word           <= '0;
      byte_cnt       <= '0;
      reply          <= '0;
      bus.tx_start   <= 1'b0;
      bus.tx_data    <= '0;
      bus.mem_addr   <= BASE_ADDR;
      bus.mem_wdata  <= '0;
      bus.mem_wmask  <= 4'h0;
      cpu_resetn     <= 1'b1;
      loading        <= 1'b0;
      load_error     <= 1'b0;
    end else begin
      bus.tx_start  <= 1'b0;
      bus.mem_wmask <= 4'h0;

      case (state)
        S_IDLE: begin
          if (bus.rx_valid && (bus.rx_data == SYNC0)) state <= S_SYNC1;
        end

        S_SYNC1: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == SYNC1) begin
              state      <= S_LEN0;
              cpu_resetn <= 1'b0;
              loading    <= 1'b1;
            end else if (bus.rx_data != SYNC0) begin
              state <= S_IDLE;
            end
          end else if (tmo_expired) begin
            state <= S_IDLE;
          end
        end

        S_LEN0: begin
          if (bus.rx_valid) begin
            len[7:0] <= bus.rx_data;
            state    <= S_LEN1;
          end else if (tmo_expired) begin
            reply <= NAK;
            state <= S_REPLY;
          end
        end

        S_LEN1: begin
          if (bus.rx_valid) begin
            len[15:8] <= bus.rx_data;
            if (len_bad) begin
              reply <= NAK;
              state <= S_REPLY;
            end else begin
              idx      <= '0;
              csum     <= '0;
              byte_cnt <= '0;
              state    <= S_DATA;
            end
          end else if (tmo_expired) begin
            reply <= NAK;
            state <= S_REPLY;
          end
        end

        S_DATA: begin
          if (bus.rx_valid) begin
            csum     <= csum + bus.rx_data;
            word     <= word_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              bus.mem_wmask <= 4'hF;
              bus.mem_wdata <= word_next;
              bus.mem_addr  <= word_addr(BASE_ADDR, idx);
              idx           <= idx + 16'd1;
              // len >= 1 here, so len - 1 cannot wrap.
              if (idx == len - 16'd1) state <= S_CSUM;
            end
          end else if (tmo_expired) begin
            reply <= NAK;
            state <= S_REPLY;
          end
        end

        S_CSUM: begin
          if (bus.rx_valid) begin
            reply <= (bus.rx_data == csum) ? ACK : NAK;
            state <= S_REPLY;
          end else if (tmo_expired) begin
            reply <= NAK;
            state <= S_REPLY;
          end
        end

        S_REPLY: begin
          if (!bus.tx_busy) begin
            bus.tx_start <= 1'b1;
            bus.tx_data  <= reply;
            loading      <= 1'b0;
            // On NAK the CPU stays held: RAM contents are not trusted.
            if (reply == ACK) begin
              cpu_resetn <= 1'b1;
              load_error <= 1'b0;
            end else begin
              load_error <= 1'b1;
            end
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: table-driven frames, hand sequences
// for sync latency, tx_busy, timeout and mid-load reset, plus random frames.
module tb_uart_loader;
  import loader_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int TMO = 300;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic cpu_resetn, loading, load_error;

  uart_loader_if bus();

  uart_loader #(
    .BASE_ADDR      (BASE),
    .MAX_WORDS      (8192),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus),
    .cpu_resetn (cpu_resetn),
    .loading    (loading),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  reply_q[$];
  logic        prev_rxv = 1'b0;
  logic        rstn_dropped = 1'b0;
  logic [31:0] pay [0:15];
  int          max_gap = 0;

  typedef struct {
    logic [15:0] len;
    int          nsent;
    logic [7:0]  csum_delta;
    logic        send_csum;
    logic [7:0]  exp_reply;
    int          exp_writes;
    logic        exp_err;
    logic        exp_rstn;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus observer: collects writes and replies, checks write pulse shape.
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.mem_wmask != 4'h0) begin
        chk("wmask_value", 32'(bus.mem_wmask), 32'h0000_000F);
        chk("write_latency", 32'(prev_rxv), 32'd1);
        wr_addr_q.push_back(bus.mem_addr);
        wr_data_q.push_back(bus.mem_wdata);
      end
      if (bus.tx_start) reply_q.push_back(bus.tx_data);
      if (!cpu_resetn) rstn_dropped = 1'b1;
    end
    prev_rxv = bus.rx_valid;
  end

  function automatic logic [7:0] pay_sum(input int n);
    logic [7:0] s;
    s = 8'd0;
    for (int i = 0; i < n; i++)
      s = s + pay[i][7:0] + pay[i][15:8] + pay[i][23:16] + pay[i][31:24];
    return s;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    repeat ($urandom_range(max_gap)) @(posedge clk);
  endtask

  task automatic send_header(input logic [15:0] n);
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic send_words(input int nw);
    for (int i = 0; i < nw; i++)
      for (int k = 0; k < 4; k++)
        send_byte(pay[i][8*k +: 8]);
  endtask

  task automatic wait_reply(input string name, input int budget);
    int c;
    c = 0;
    while (reply_q.size() == 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    chk({name, "_reply_seen"}, 32'(reply_q.size() != 0), 32'd1);
  endtask

  task automatic check_frame(input string name, input logic [7:0] exp_reply, input int exp_writes,
                             input logic exp_err, input logic exp_rstn);
    logic [7:0] r;
    wait_reply(name, 200);
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_nreplies"}, 32'(reply_q.size()), 32'd1);
    r = 8'hFF;
    if (reply_q.size() > 0) r = reply_q.pop_front();
    chk({name, "_reply"}, 32'(r), 32'(exp_reply));
    chk({name, "_nwrites"}, 32'(wr_addr_q.size()), 32'(exp_writes));
    for (int i = 0; i < exp_writes && i < wr_addr_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", name, i), wr_addr_q[i], BASE + 32'(4 * i));
      chk($sformatf("%s_data%0d", name, i), wr_data_q[i], pay[i]);
    end
    chk({name, "_load_error"}, 32'(load_error), 32'(exp_err));
    chk({name, "_cpu_resetn"}, 32'(cpu_resetn), 32'(exp_rstn));
    chk({name, "_loading"}, 32'(loading), 32'd0);
    reply_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic check_reset_values(input string name);
    chk({name, "_mem_addr"}, bus.mem_addr, BASE);
    chk({name, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    chk({name, "_mem_wmask"}, 32'(bus.mem_wmask), 32'd0);
    chk({name, "_tx_start"}, 32'(bus.tx_start), 32'd0);
    chk({name, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    chk({name, "_cpu_resetn"}, 32'(cpu_resetn), 32'd1);
    chk({name, "_loading"}, 32'(loading), 32'd0);
    chk({name, "_load_error"}, 32'(load_error), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cs;
    logic       corrupt;
    int         n;
    int         c;
    logic [7:0] nb;

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_busy  = 1'b0;

    pay[0] = 32'h1234_5678;
    pay[1] = 32'hDEAD_BEEF;
    for (int i = 2; i < 16; i++) pay[i] = $urandom;

    // {len, nsent, csum_delta, send_csum, exp_reply, exp_writes, exp_err, exp_rstn}
    vecs[0] = '{16'd2,    2, 8'h00, 1'b1, ACK, 2, 1'b0, 1'b1};
    vecs[1] = '{16'd2,    2, 8'h01, 1'b1, NAK, 2, 1'b1, 1'b0};
    vecs[2] = '{16'd2,    2, 8'h00, 1'b1, ACK, 2, 1'b0, 1'b1};
    vecs[3] = '{16'd0,    0, 8'h00, 1'b0, NAK, 0, 1'b1, 1'b0};
    vecs[4] = '{16'd8193, 0, 8'h00, 1'b0, NAK, 0, 1'b1, 1'b0};
    vecs[5] = '{16'd3,    3, 8'h80, 1'b1, NAK, 3, 1'b1, 1'b0};
    vecs[6] = '{16'd1,    1, 8'h00, 1'b1, ACK, 1, 1'b0, 1'b1};

    #2;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    resetn = 1'b1;

    // Noise while idle: no writes, no reply, CPU never held.
    rstn_dropped = 1'b0;
    send_byte(8'h55);
    send_byte(8'h55);
    send_byte(8'h12);
    repeat (20) @(posedge clk);
    chk("noise_nwrites", 32'(wr_addr_q.size()), 32'd0);
    chk("noise_nreplies", 32'(reply_q.size()), 32'd0);
    chk("noise_rstn_dropped", 32'(rstn_dropped), 32'd0);

    // cpu_resetn/loading change exactly one cycle after 0xAA is delivered.
    send_byte(8'h55);
    @(posedge clk); #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hAA;
    chk("sync_rstn_before", 32'(cpu_resetn), 32'd1);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    chk("sync_rstn_after", 32'(cpu_resetn), 32'd0);
    chk("sync_loading_after", 32'(loading), 32'd1);
    send_byte(8'h01);
    send_byte(8'h00);
    send_words(1);
    send_byte(pay_sum(1));
    check_frame("sync", ACK, 1, 1'b0, 1'b1);

    for (int v = 0; v < 7; v++) begin
      send_header(vecs[v].len);
      send_words(vecs[v].nsent);
      cs = pay_sum(vecs[v].nsent) + vecs[v].csum_delta;
      if (vecs[v].send_csum) send_byte(cs);
      check_frame($sformatf("vec%0d", v), vecs[v].exp_reply, vecs[v].exp_writes,
                  vecs[v].exp_err, vecs[v].exp_rstn);
    end

    // Reply held off while the transmitter is busy.
    bus.tx_busy = 1'b1;
    send_header(16'd1);
    send_words(1);
    send_byte(pay_sum(1));
    repeat (20) @(posedge clk);
    chk("busy_no_reply", 32'(reply_q.size()), 32'd0);
    chk("busy_loading", 32'(loading), 32'd1);
    bus.tx_busy = 1'b0;
    check_frame("busy", ACK, 1, 1'b0, 1'b1);

    // Random frames with noise prefixes and byte gaps.
    max_gap = 2;
    for (int it = 0; it < 10; it++) begin
      for (int j = 0; j < int'($urandom_range(2)); j++) begin
        nb = 8'($urandom);
        if (nb == 8'h55) nb = 8'h56;
        send_byte(nb);
      end
      n = int'($urandom_range(6, 1));
      for (int i = 0; i < n; i++) pay[i] = $urandom;
      corrupt = ($urandom_range(2) == 0);
      cs = pay_sum(n) + (corrupt ? 8'($urandom_range(255, 1)) : 8'd0);
      send_header(16'(n));
      send_words(n);
      send_byte(cs);
      check_frame($sformatf("rand%0d", it), corrupt ? NAK : ACK, n, corrupt, !corrupt);
    end
    max_gap = 0;

    // Stream stalls after 5 payload bytes of an N=4 frame.
    send_header(16'd4);
    send_words(1);
    send_byte(pay[1][7:0]);
    c = 0;
    while (reply_q.size() == 0 && c < TMO + 50) begin
      @(posedge clk);
      c++;
    end
    chk("timeout_delay_in_window", 32'(c >= TMO && c <= TMO + 3), 32'd1);
    check_frame("timeout", NAK, 1, 1'b1, 1'b0);

    // Reset in the middle of DATA, then a fresh load.
    send_header(16'd3);
    send_words(1);
    send_byte(pay[1][7:0]);
    send_byte(pay[1][15:8]);
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    check_reset_values("midreset");
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    reply_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    pay[0] = $urandom;
    pay[1] = $urandom;
    send_header(16'd2);
    send_words(2);
    send_byte(pay_sum(2));
    check_frame("after_reset", ACK, 2, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
